// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Registered state (RUN/FLUSH/LDSTALL/HALT) plus saturating stall and flush
// counters; every enable/flush output is combinational from state and inputs.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        mem_busy,
    input  logic        halt_req,
    input  logic        cnt_clr,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_LDSTALL = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_redirect;
    logic w_flush_evt;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_en;

    // Hazard qualifiers: load-use against a non-zero destination, and any redirect.
    always_comb begin
        w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));
        w_redirect = branch_taken || jump;
    end

    // Next-state and enable/flush decode; priority mem_busy > redirect > halt > load-use.
    always_comb begin
        w_next       = r_state;
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_exmem_en   = 1'b1;
        w_flush_evt  = 1'b0;
        if (!rst) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_exmem_en   = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_next       = ST_RUN;
        end else if (mem_busy) begin
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_exmem_en = 1'b0;
            w_next     = r_state;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    // Second bubble; redirect, halt and load-use are ignored here.
                    w_ifid_flush = 1'b1;
                    w_next       = ST_RUN;
                end
                ST_RUN, ST_LDSTALL, ST_HALT: begin
                    if (w_redirect) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                        w_flush_evt  = 1'b1;
                        w_next       = ST_FLUSH;
                    end else if (r_state == ST_HALT) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                        w_next       = halt_req ? ST_HALT : ST_RUN;
                    end else if (r_state == ST_LDSTALL) begin
                        // Load-use detection suppressed: the stall lasts one cycle.
                        w_next = ST_RUN;
                    end else if (halt_req) begin
                        w_next = ST_HALT;
                    end else if (w_load_use) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                        w_next       = ST_LDSTALL;
                    end else begin
                        w_next = ST_RUN;
                    end
                end
                default: w_next = ST_RUN;
            endcase
        end
    end

    // State register and saturating counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (cnt_clr) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (!w_pc_en && (r_stall_cnt != CNT_MAX))
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                if (w_flush_evt && (r_flush_cnt != CNT_MAX))
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_en      = w_pc_en;
    assign ifid_en    = w_ifid_en;
    assign ifid_flush = w_ifid_flush;
    assign idex_flush = w_idex_flush;
    assign exmem_en   = w_exmem_en;
    assign state      = r_state;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule
